// File: rtl/settings_bus_master_pkg.sv
// Purpose: shared types for the settings-bus master: opcodes, FSM states, command and response header layouts.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
package settings_bus_master_pkg;

    // Command opcodes carried in cmd_tdata[63:62].
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_WR_RD = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ      = 3'd2,
        ST_RB_WAIT   = 3'd3,
        ST_RESP_HDR  = 3'd4,
        ST_RESP_DATA = 3'd5
    } state_t;

    // Command beat layout:
    //   [63:62] op, [61:56] reserved, [55:48] seq, [47:40] addr, [39:32] reserved, [31:0] data
    typedef struct packed {
        op_t         op;
        logic [5:0]  rsvd_hi;
        logic [7:0]  seq;
        logic [7:0]  addr;
        logic [7:0]  rsvd_lo;
        logic [31:0] data;
    } cmd_t;

    // Response header layout:
    //   [63:62] op, [61] err, [60:56] zero, [55:48] seq, [47:40] zero, [39:32] addr, [31:0] data
    // Note addr moves down one byte relative to the command beat.
    typedef struct packed {
        op_t         op;
        logic        err;
        logic [4:0]  zero_hi;
        logic [7:0]  seq;
        logic [7:0]  zero_lo;
        logic [7:0]  addr;
        logic [31:0] data;
    } resp_hdr_t;

    function automatic logic [63:0] build_hdr(input cmd_t c, input logic err);
        resp_hdr_t h;
        h         = '0;
        h.op      = c.op;
        h.err     = err;
        h.seq     = c.seq;
        h.addr    = c.addr;
        h.data    = c.data;
        return h;
    endfunction

    // Ops whose data beat carries readback data rather than zero.
    function automatic logic op_has_rb(input op_t op);
        return (op == OP_READ) || (op == OP_WR_RD);
    endfunction

endpackage

// File: rtl/settings_bus_master_rb_delay.sv
// Purpose: readback latency timer; emits a one-cycle capture pulse RB_LATENCY cycles after start.
// Latency: cap high in the cycle exactly RB_LATENCY after the start cycle.
// Backpressure: none; a new start restarts the count.
// Ports: ce_clk/ce_rst clock and sync reset; start = rb_stb cycle; cap = sample rb_data this cycle.
module settings_bus_master_rb_delay #(
    parameter int RB_LATENCY = 1
) (
    input  logic ce_clk,
    input  logic ce_rst,
    input  logic start,
    output logic cap
);

    logic [3:0] cnt;
    logic       busy;

    // Load RB_LATENCY-1 at the end of the start cycle; the pulse fires when the
    // counter reaches zero, which lands RB_LATENCY cycles after start.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            cnt  <= 4'd0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= 4'(RB_LATENCY - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == 4'd0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign cap = busy && (cnt == 4'd0);

endmodule

// File: rtl/settings_bus_master.sv
// Purpose: executes one 64-bit command beat as a settings-bus write and/or readback, returns a 2-beat response.
// Latency: write: set_stb N+1, header N+2, data N+3; read: rb_stb N+1, header N+2+RB_LATENCY.
// Backpressure: resp_tready stalls the response indefinitely; cmd_tready is low until the response is fully accepted.
// Ports: ce_clk, ce_rst (sync, active high); cmd_* command stream in; set_* settings write bus;
//        rb_* readback bus; resp_* response stream out.
// Build option: define SETTINGS_BUS_MASTER_OPCHK_EN to reject reserved opcode 11 with err=1 and no strobes;
//        otherwise op 11 behaves exactly like a write.
module settings_bus_master
    import settings_bus_master_pkg::*;
#(
    parameter int RB_LATENCY = 1
) (
    input  logic        ce_clk,
    input  logic        ce_rst,

    input  logic [63:0] cmd_tdata,
    input  logic        cmd_tvalid,
    input  logic        cmd_tlast,
    output logic        cmd_tready,

    output logic        set_stb,
    output logic [7:0]  set_addr,
    output logic [31:0] set_data,

    output logic        rb_stb,
    output logic [7:0]  rb_addr,
    input  logic [63:0] rb_data,

    output logic [63:0] resp_tdata,
    output logic        resp_tvalid,
    output logic        resp_tlast,
    input  logic        resp_tready
);

    state_t      state;
    cmd_t        cmd_in;
    cmd_t        cmd_q;
    logic        err_q;
    logic [63:0] rb_q;
    logic        rb_cap;

    assign cmd_in = cmd_t'(cmd_tdata);

    // Every beat is a full command, so tlast carries no information; reserved
    // command fields are likewise ignored.
    logic unused_bits;
    assign unused_bits = &{1'b0, cmd_tlast, cmd_q.rsvd_hi, cmd_q.rsvd_lo};

    settings_bus_master_rb_delay #(
        .RB_LATENCY (RB_LATENCY)
    ) u_rb_delay (
        .ce_clk (ce_clk),
        .ce_rst (ce_rst),
        .start  (rb_stb),
        .cap    (rb_cap)
    );

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            err_q       <= 1'b0;
            rb_q        <= '0;
            cmd_tready  <= 1'b0;
            set_stb     <= 1'b0;
            set_addr    <= '0;
            set_data    <= '0;
            rb_stb      <= 1'b0;
            rb_addr     <= '0;
            resp_tdata  <= '0;
            resp_tvalid <= 1'b0;
            resp_tlast  <= 1'b0;
        end else begin
            // Strobes are single-cycle; they are only raised on state entry below.
            set_stb <= 1'b0;
            rb_stb  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cmd_tready <= 1'b1;
                    if (cmd_tvalid && cmd_tready) begin
                        cmd_tready <= 1'b0;
                        cmd_q      <= cmd_in;
                        err_q      <= 1'b0;
                        if (cmd_in.op == OP_READ) begin
                            state   <= ST_READ;
                            rb_stb  <= 1'b1;
                            rb_addr <= cmd_in.addr;
                        end
`ifdef SETTINGS_BUS_MASTER_OPCHK_EN
                        else if (cmd_in.op == OP_RSVD) begin
                            // Reserved op: no bus activity, straight to an error response.
                            err_q       <= 1'b1;
                            state       <= ST_RESP_HDR;
                            resp_tvalid <= 1'b1;
                            resp_tlast  <= 1'b0;
                            resp_tdata  <= build_hdr(cmd_in, 1'b1);
                        end
`endif
                        else begin
                            state    <= ST_WRITE;
                            set_stb  <= 1'b1;
                            set_addr <= cmd_in.addr;
                            set_data <= cmd_in.data;
                        end
                    end
                end

                ST_WRITE: begin
                    if (cmd_q.op == OP_WR_RD) begin
                        // Readback strobe follows the write strobe by one cycle.
                        state   <= ST_READ;
                        rb_stb  <= 1'b1;
                        rb_addr <= cmd_q.addr;
                    end else begin
                        state       <= ST_RESP_HDR;
                        resp_tvalid <= 1'b1;
                        resp_tlast  <= 1'b0;
                        resp_tdata  <= build_hdr(cmd_q, err_q);
                    end
                end

                ST_READ: begin
                    state <= ST_RB_WAIT;
                end

                ST_RB_WAIT: begin
                    if (rb_cap) begin
                        rb_q        <= rb_data;
                        state       <= ST_RESP_HDR;
                        resp_tvalid <= 1'b1;
                        resp_tlast  <= 1'b0;
                        resp_tdata  <= build_hdr(cmd_q, err_q);
                    end
                end

                ST_RESP_HDR: begin
                    if (resp_tready) begin
                        state      <= ST_RESP_DATA;
                        resp_tlast <= 1'b1;
                        resp_tdata <= op_has_rb(cmd_q.op) ? rb_q : 64'd0;
                    end
                end

                ST_RESP_DATA: begin
                    if (resp_tready) begin
                        state       <= ST_IDLE;
                        resp_tvalid <= 1'b0;
                        resp_tlast  <= 1'b0;
                        cmd_tready  <= 1'b1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    cmd_tready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_settings_bus_master.sv
// Purpose: directed self-checking bench for settings_bus_master at RB_LATENCY 1 and 3.
// Latency: n/a.
// Backpressure: resp_tready driven directly, including a long stall.
module tb_settings_bus_master;

    logic        ce_clk;
    logic        ce_rst;
    logic [63:0] cmd_tdata;
    logic        cmd_tlast;
    logic        resp_tready;

    logic        cmd_tvalid1, cmd_tready1, set_stb1, rb_stb1, resp_tvalid1, resp_tlast1;
    logic [7:0]  set_addr1, rb_addr1;
    logic [31:0] set_data1;
    logic [63:0] rb_data1, resp_tdata1, rb_val1;

    logic        cmd_tvalid3, cmd_tready3, set_stb3, rb_stb3, resp_tvalid3, resp_tlast3;
    logic [7:0]  set_addr3, rb_addr3;
    logic [31:0] set_data3;
    logic [63:0] rb_data3, resp_tdata3, rb_val3;

    int n_cmp = 0;
    int n_err = 0;
    int since1 = 0;
    int since3 = 0;

    settings_bus_master #(.RB_LATENCY(1)) u_dut1 (
        .ce_clk      (ce_clk),
        .ce_rst      (ce_rst),
        .cmd_tdata   (cmd_tdata),
        .cmd_tvalid  (cmd_tvalid1),
        .cmd_tlast   (cmd_tlast),
        .cmd_tready  (cmd_tready1),
        .set_stb     (set_stb1),
        .set_addr    (set_addr1),
        .set_data    (set_data1),
        .rb_stb      (rb_stb1),
        .rb_addr     (rb_addr1),
        .rb_data     (rb_data1),
        .resp_tdata  (resp_tdata1),
        .resp_tvalid (resp_tvalid1),
        .resp_tlast  (resp_tlast1),
        .resp_tready (resp_tready)
    );

    settings_bus_master #(.RB_LATENCY(3)) u_dut3 (
        .ce_clk      (ce_clk),
        .ce_rst      (ce_rst),
        .cmd_tdata   (cmd_tdata),
        .cmd_tvalid  (cmd_tvalid3),
        .cmd_tlast   (cmd_tlast),
        .cmd_tready  (cmd_tready3),
        .set_stb     (set_stb3),
        .set_addr    (set_addr3),
        .set_data    (set_data3),
        .rb_stb      (rb_stb3),
        .rb_addr     (rb_addr3),
        .rb_data     (rb_data3),
        .resp_tdata  (resp_tdata3),
        .resp_tvalid (resp_tvalid3),
        .resp_tlast  (resp_tlast3),
        .resp_tready (resp_tready)
    );

    initial ce_clk = 1'b0;
    always #5 ce_clk = ~ce_clk;

    // Readback models: valid data only in the cycle exactly RB_LATENCY after
    // rb_stb, a poison pattern in every other cycle.
    always @(posedge ce_clk) begin
        if (ce_rst) since1 <= 0;
        else if (rb_stb1) since1 <= 1;
        else if (since1 != 0 && since1 < 1000) since1 <= since1 + 1;
    end
    always @(posedge ce_clk) begin
        if (ce_rst) since3 <= 0;
        else if (rb_stb3) since3 <= 1;
        else if (since3 != 0 && since3 < 1000) since3 <= since3 + 1;
    end
    assign rb_data1 = (since1 == 1) ? rb_val1 : 64'hBAD0_BAD0_BAD0_BAD0;
    assign rb_data3 = (since3 == 3) ? rb_val3 : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic tick();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        ce_rst      = 1'b1;
        cmd_tdata   = '0;
        cmd_tlast   = 1'b1;
        cmd_tvalid1 = 1'b0;
        cmd_tvalid3 = 1'b0;
        resp_tready = 1'b0;
        rb_val1     = '0;
        rb_val3     = '0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_cmd_tready",  64'(cmd_tready1),  64'd0);
        chk("rst_set_stb",     64'(set_stb1),     64'd0);
        chk("rst_rb_stb",      64'(rb_stb1),      64'd0);
        chk("rst_resp_tvalid", 64'(resp_tvalid1), 64'd0);
        chk("rst_resp_tlast",  64'(resp_tlast1),  64'd0);
        chk("rst_set_addr",    64'(set_addr1),    64'd0);
        chk("rst_set_data",    64'(set_data1),    64'd0);
        chk("rst_rb_addr",     64'(rb_addr1),     64'd0);
        chk("rst_resp_tdata",  resp_tdata1,       64'd0);
        chk("rst_cmd_tready3", 64'(cmd_tready3),  64'd0);
        ce_rst = 1'b0;
        tick();
        chk("rdy_after_rst",  64'(cmd_tready1), 64'd1);
        chk("rdy_after_rst3", 64'(cmd_tready3), 64'd1);

        // ---------------- write, op 00 ----------------
        resp_tready = 1'b1;
        cmd_tdata   = 64'h0005_8000_1234_5678;
        cmd_tvalid1 = 1'b1;
        chk("wr_rdy_n", 64'(cmd_tready1), 64'd1);
        tick();                                     // N+1
        cmd_tvalid1 = 1'b0;
        chk("wr_set_stb",    64'(set_stb1),    64'd1);
        chk("wr_set_addr",   64'(set_addr1),   64'h80);
        chk("wr_set_data",   64'(set_data1),   64'h1234_5678);
        chk("wr_rb_stb",     64'(rb_stb1),     64'd0);
        chk("wr_rdy_busy",   64'(cmd_tready1), 64'd0);
        tick();                                     // N+2
        chk("wr_set_stb_off", 64'(set_stb1),     64'd0);
        chk("wr_hdr_vld",     64'(resp_tvalid1), 64'd1);
        chk("wr_hdr_last",    64'(resp_tlast1),  64'd0);
        chk("wr_hdr",         resp_tdata1,       64'h0005_0080_1234_5678);
        tick();                                     // N+3
        chk("wr_dat_vld",  64'(resp_tvalid1), 64'd1);
        chk("wr_dat_last", 64'(resp_tlast1),  64'd1);
        chk("wr_dat",      resp_tdata1,       64'd0);
        tick();                                     // N+4
        chk("wr_done_vld",  64'(resp_tvalid1), 64'd0);
        chk("wr_done_rdy",  64'(cmd_tready1),  64'd1);
        chk("wr_addr_hold", 64'(set_addr1),    64'h80);

        // ---------------- read, op 01, latency 1 ----------------
        cmd_tdata   = 64'h4011_0100_AAAA_5555;
        rb_val1     = 64'h0000_0000_0000_0004;
        cmd_tvalid1 = 1'b1;
        tick();                                     // N+1
        cmd_tvalid1 = 1'b0;
        chk("rd_rb_stb",  64'(rb_stb1),  64'd1);
        chk("rd_rb_addr", 64'(rb_addr1), 64'h01);
        chk("rd_set_stb", 64'(set_stb1), 64'd0);
        tick();                                     // N+2 capture cycle
        chk("rd_rb_stb_off", 64'(rb_stb1),      64'd0);
        chk("rd_set_stb2",   64'(set_stb1),     64'd0);
        chk("rd_no_hdr_yet", 64'(resp_tvalid1), 64'd0);
        tick();                                     // N+3
        chk("rd_hdr_vld",  64'(resp_tvalid1), 64'd1);
        chk("rd_hdr_last", 64'(resp_tlast1),  64'd0);
        chk("rd_hdr",      resp_tdata1,       64'h4011_0001_AAAA_5555);
        tick();                                     // N+4
        chk("rd_dat_last", 64'(resp_tlast1), 64'd1);
        chk("rd_dat",      resp_tdata1,      64'h4);
        tick();                                     // N+5
        chk("rd_done_rdy",   64'(cmd_tready1), 64'd1);
        chk("rd_addr_hold",  64'(rb_addr1),    64'h01);

        // ---------------- 20-cycle header stall, second command waiting ----------------
        resp_tready = 1'b0;
        cmd_tdata   = 64'h0022_1000_CAFE_F00D;
        cmd_tvalid1 = 1'b1;
        tick();                                     // N+1
        cmd_tdata   = 64'h4033_0200_0000_0000;      // next command held valid during stall
        tick();                                     // N+2
        for (int i = 0; i < 20; i++) begin
            chk("stall_hdr", resp_tdata1,       64'h0022_0010_CAFE_F00D);
            chk("stall_vld", 64'(resp_tvalid1), 64'd1);
            chk("stall_rdy", 64'(cmd_tready1),  64'd0);
            tick();
        end
        chk("stall_hdr_end", resp_tdata1, 64'h0022_0010_CAFE_F00D);
        chk("stall_last",    64'(resp_tlast1), 64'd0);
        resp_tready = 1'b1;
        rb_val1     = 64'h0123_4567_89AB_CDEF;
        tick();
        chk("stall_dat",      resp_tdata1,      64'd0);
        chk("stall_dat_last", 64'(resp_tlast1), 64'd1);
        tick();                                     // IDLE, second command accepted here
        chk("stall_rdy_back", 64'(cmd_tready1), 64'd1);
        tick();
        cmd_tvalid1 = 1'b0;
        chk("q2_rb_stb",  64'(rb_stb1),  64'd1);
        chk("q2_rb_addr", 64'(rb_addr1), 64'h02);
        tick();
        tick();
        chk("q2_hdr", resp_tdata1, 64'h4033_0002_0000_0000);
        tick();
        chk("q2_dat",      resp_tdata1,      64'h0123_4567_89AB_CDEF);
        chk("q2_dat_last", 64'(resp_tlast1), 64'd1);
        tick();
        chk("q2_done", 64'(cmd_tready1), 64'd1);

        // ---------------- write-then-read, op 10, latency 3 ----------------
        cmd_tdata   = 64'h8044_8100_0000_0007;
        rb_val3     = 64'hFEED_FACE_0000_0081;
        cmd_tvalid3 = 1'b1;
        chk("wrd_rdy_n", 64'(cmd_tready3), 64'd1);
        tick();                                     // N+1
        cmd_tvalid3 = 1'b0;
        chk("wrd_set_stb",  64'(set_stb3),  64'd1);
        chk("wrd_set_addr", 64'(set_addr3), 64'h81);
        chk("wrd_set_data", 64'(set_data3), 64'h7);
        chk("wrd_rb_early", 64'(rb_stb3),   64'd0);
        tick();                                     // N+2
        chk("wrd_rb_stb",   64'(rb_stb3),   64'd1);
        chk("wrd_rb_addr",  64'(rb_addr3),  64'h81);
        chk("wrd_set_off",  64'(set_stb3),  64'd0);
        for (int i = 0; i < 3; i++) begin           // N+3..N+5 waiting
            tick();
            chk("wrd_wait_vld", 64'(resp_tvalid3), 64'd0);
            chk("wrd_wait_rb",  64'(rb_stb3),      64'd0);
        end
        tick();                                     // N+6
        chk("wrd_hdr_vld", 64'(resp_tvalid3), 64'd1);
        chk("wrd_hdr",     resp_tdata3,       64'h8044_0081_0000_0007);
        tick();                                     // N+7
        chk("wrd_dat",      resp_tdata3,      64'hFEED_FACE_0000_0081);
        chk("wrd_dat_last", 64'(resp_tlast3), 64'd1);
        tick();                                     // N+8
        chk("wrd_done", 64'(cmd_tready3), 64'd1);

        // ---------------- reserved op 11 ----------------
        cmd_tdata   = 64'hC055_2000_DEAD_BEEF;
        cmd_tvalid1 = 1'b1;
        tick();                                     // N+1
        cmd_tvalid1 = 1'b0;
`ifdef SETTINGS_BUS_MASTER_OPCHK_EN
        chk("op11_no_set", 64'(set_stb1),     64'd0);
        chk("op11_no_rb",  64'(rb_stb1),      64'd0);
        chk("op11_hdr",    resp_tdata1,       64'hE055_0020_DEAD_BEEF);
        chk("op11_vld",    64'(resp_tvalid1), 64'd1);
        tick();
`else
        chk("op11_set_stb",  64'(set_stb1),  64'd1);
        chk("op11_set_addr", 64'(set_addr1), 64'h20);
        chk("op11_set_data", 64'(set_data1), 64'hDEAD_BEEF);
        chk("op11_no_rb",    64'(rb_stb1),   64'd0);
        tick();
        chk("op11_hdr", resp_tdata1, 64'hC055_0020_DEAD_BEEF);
        tick();
`endif
        chk("op11_dat",      resp_tdata1,      64'd0);
        chk("op11_dat_last", 64'(resp_tlast1), 64'd1);
        tick();
        chk("op11_done", 64'(cmd_tready1), 64'd1);

        // ---------------- reset during RB_WAIT ----------------
        cmd_tdata   = 64'h4066_0500_0000_0000;
        rb_val3     = 64'h1111_2222_3333_4444;
        cmd_tvalid3 = 1'b1;
        tick();                                     // N+1
        cmd_tvalid3 = 1'b0;
        chk("rw_rb_stb", 64'(rb_stb3), 64'd1);
        tick();                                     // N+2, in RB_WAIT
        ce_rst = 1'b1;
        tick();
        chk("rw_rst_rdy",    64'(cmd_tready3),  64'd0);
        chk("rw_rst_set",    64'(set_stb3),     64'd0);
        chk("rw_rst_rb",     64'(rb_stb3),      64'd0);
        chk("rw_rst_vld",    64'(resp_tvalid3), 64'd0);
        chk("rw_rst_last",   64'(resp_tlast3),  64'd0);
        chk("rw_rst_saddr",  64'(set_addr3),    64'd0);
        chk("rw_rst_sdata",  64'(set_data3),    64'd0);
        chk("rw_rst_rbaddr", 64'(rb_addr3),     64'd0);
        chk("rw_rst_tdata",  resp_tdata3,       64'd0);
        ce_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rw_no_resp", 64'(resp_tvalid3), 64'd0);
            chk("rw_no_rb",   64'(rb_stb3),      64'd0);
        end
        chk("rw_rdy_back", 64'(cmd_tready3), 64'd1);
        cmd_tdata   = 64'h0077_0900_0000_0055;
        cmd_tvalid3 = 1'b1;
        tick();
        cmd_tvalid3 = 1'b0;
        chk("rw_next_set",  64'(set_stb3),  64'd1);
        chk("rw_next_addr", 64'(set_addr3), 64'h09);
        tick();
        chk("rw_next_hdr", resp_tdata3, 64'h0077_0009_0000_0055);
        tick();
        chk("rw_next_dat",  resp_tdata3,      64'd0);
        chk("rw_next_last", 64'(resp_tlast3), 64'd1);
        tick();
        chk("rw_next_done", 64'(cmd_tready3), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
